// File: rtl/dma_mm2s_reader_if.sv
// Descriptor, AXI4 read (AR/R), AXIS and status signals of one MM2S read engine.
// master = the reader itself, slave = the controller/interconnect/sink around it.
interface dma_mm2s_reader_if #(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 128,
    parameter int AXI_LEN_WIDTH   = 32,
    parameter int AXIS_USER_WIDTH = 65
);
    logic [AXI_ADDR_WIDTH-1:0]  s_desc_addr;
    logic [AXI_LEN_WIDTH-1:0]   s_desc_len;
    logic [AXIS_USER_WIDTH-1:0] s_desc_user;
    logic                       s_desc_valid;
    logic                       s_desc_ready;

    logic [AXI_ADDR_WIDTH-1:0]  m_axi_araddr;
    logic [7:0]                 m_axi_arlen;
    logic [2:0]                 m_axi_arsize;
    logic [1:0]                 m_axi_arburst;
    logic                       m_axi_arvalid;
    logic                       m_axi_arready;

    logic [AXI_DATA_WIDTH-1:0]  m_axi_rdata;
    logic [1:0]                 m_axi_rresp;
    logic                       m_axi_rlast;
    logic                       m_axi_rvalid;
    logic                       m_axi_rready;

    logic [AXI_DATA_WIDTH-1:0]  m_axis_tdata;
    logic [AXIS_USER_WIDTH-1:0] m_axis_tuser;
    logic                       m_axis_tlast;
    logic                       m_axis_tvalid;
    logic                       m_axis_tready;

    logic                       done;
    logic                       err;

    modport master (
        input  s_desc_addr, s_desc_len, s_desc_user, s_desc_valid,
        output s_desc_ready,
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
        input  m_axis_tready,
        output done, err
    );

    modport slave (
        output s_desc_addr, s_desc_len, s_desc_user, s_desc_valid,
        input  s_desc_ready,
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
        output m_axis_tready,
        input  done, err
    );
endinterface

// File: rtl/dma_mm2s_reader.sv
// Splits one read descriptor into 4 KB-safe AXI4 bursts and streams R beats out as AXIS.
// AR one cycle after descriptor accept; R->AXIS is combinational, so tready backpressures R directly.
module dma_mm2s_reader #(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 128,
    parameter int AXI_LEN_WIDTH   = 32,
    parameter int AXIS_USER_WIDTH = 65,
    parameter int MAX_BURST_BEATS = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic               clk,
    input  logic               rst,
    dma_mm2s_reader_if.master  bus
);
    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                     state;
    logic [AXI_ADDR_WIDTH-1:0]  araddr_q;
    logic [7:0]                 arlen_q;
    logic                       arvalid_q;
    logic [AXI_LEN_WIDTH-1:0]   rem_ar;
    logic [AXI_LEN_WIDTH-1:0]   total_beats;
    logic [AXI_LEN_WIDTH-1:0]   beat_cnt;
    logic [OUT_W-1:0]           outstanding;
    logic [OUT_W-1:0]           out_nxt;
    logic [AXIS_USER_WIDTH-1:0] user_q;
    logic                       err_q;
    logic                       done_q;
    logic                       rdy_q;

    logic                       active;
    logic                       desc_hs;
    logic                       ar_hs;
    logic                       r_hs;
    logic                       rlast_hs;
    logic                       tlast;
    logic [8:0]                 cur_beats;
    logic [AXI_ADDR_WIDTH-1:0]  next_addr;
    logic [AXI_LEN_WIDTH-1:0]   next_rem;
    logic [AXI_ADDR_WIDTH-1:0]  desc_addr_al;
    logic [AXI_LEN_WIDTH-1:0]   desc_beats;

    // Beats in the next burst: limited by what is left, the burst cap and the 4 KB page end.
    function automatic logic [8:0] burst_of(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                            input logic [AXI_LEN_WIDTH-1:0]  rem);
        logic [12:0]              page;
        logic [AXI_LEN_WIDTH-1:0] b;
        page = (13'd4096 - {1'b0, addr[11:0]}) >> SIZE;
        b    = rem;
        if (b > AXI_LEN_WIDTH'(MAX_BURST_BEATS)) b = AXI_LEN_WIDTH'(MAX_BURST_BEATS);
        if (b > AXI_LEN_WIDTH'(page))            b = AXI_LEN_WIDTH'(page);
        return b[8:0];
    endfunction

    assign active       = (state != IDLE);
    assign desc_hs      = rdy_q && bus.s_desc_valid;
    assign ar_hs        = arvalid_q && bus.m_axi_arready;
    assign r_hs         = bus.m_axi_rvalid && bus.m_axis_tready && active;
    assign rlast_hs     = r_hs && bus.m_axi_rlast;
    assign tlast        = active && (beat_cnt == total_beats - AXI_LEN_WIDTH'(1));
    assign cur_beats    = {1'b0, arlen_q} + 9'd1;
    assign next_addr    = araddr_q + (AXI_ADDR_WIDTH'(cur_beats) << SIZE);
    assign next_rem     = rem_ar - AXI_LEN_WIDTH'(cur_beats);
    assign desc_addr_al = bus.s_desc_addr & ~AXI_ADDR_WIDTH'(BYTES - 1);
    assign desc_beats   = bus.s_desc_len >> SIZE;

    always_comb begin
        out_nxt = outstanding;
        if (ar_hs && !rlast_hs)
            out_nxt = outstanding + OUT_W'(1);
        else if (!ar_hs && rlast_hs && outstanding != '0)
            out_nxt = outstanding - OUT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arvalid_q   <= 1'b0;
            rem_ar      <= '0;
            total_beats <= '0;
            beat_cnt    <= '0;
            outstanding <= '0;
            user_q      <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            outstanding <= out_nxt;
            if (r_hs) beat_cnt <= beat_cnt + AXI_LEN_WIDTH'(1);
            if (r_hs && bus.m_axi_rresp != 2'b00) err_q <= 1'b1;

            case (state)
                IDLE: begin
                    if (desc_hs) begin
                        araddr_q    <= desc_addr_al;
                        rem_ar      <= desc_beats;
                        total_beats <= desc_beats;
                        beat_cnt    <= '0;
                        user_q      <= bus.s_desc_user;
                        err_q       <= 1'b0;
                        rdy_q       <= 1'b0;
                        if (desc_beats == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            arvalid_q <= 1'b1;
                            arlen_q   <= 8'(burst_of(desc_addr_al, desc_beats) - 9'd1);
                        end
                    end else begin
                        // Held low through the done cycle so the controller sees a gap.
                        rdy_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (ar_hs) begin
                        araddr_q <= next_addr;
                        rem_ar   <= next_rem;
                        if (next_rem == '0) begin
                            arvalid_q <= 1'b0;
                            state     <= DRAIN;
                        end else begin
                            arvalid_q <= (out_nxt < OUT_W'(MAX_OUTSTANDING));
                            arlen_q   <= 8'(burst_of(next_addr, next_rem) - 9'd1);
                        end
                    end else begin
                        arvalid_q <= (out_nxt < OUT_W'(MAX_OUTSTANDING));
                    end
                end
                DRAIN: begin
                    if (r_hs && tlast) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_desc_ready  = rdy_q;
    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arlen   = arlen_q;
    assign bus.m_axi_arsize  = 3'(SIZE);
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = bus.m_axis_tready && active;
    assign bus.m_axis_tdata  = bus.m_axi_rdata;
    assign bus.m_axis_tuser  = user_q;
    assign bus.m_axis_tlast  = tlast;
    assign bus.m_axis_tvalid = bus.m_axi_rvalid && active;
    assign bus.done          = done_q;
    assign bus.err           = err_q;
endmodule
